// File: rtl/maze_pkg.sv
// Shared definitions for the maze navigation controller: wall-map bit layout,
// move directions and controller states.
package maze_pkg;

    localparam int WALL_T = 3;
    localparam int WALL_B = 2;
    localparam int WALL_L = 1;
    localparam int WALL_R = 0;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_CHECK  = 2'd2
    } state_e;

    // Edge vector layout is {up, down, left, right}; up wins, right loses.
    function automatic dir_e pick_dir(input logic [3:0] edges);
        if (edges[3])      return DIR_UP;
        else if (edges[2]) return DIR_DOWN;
        else if (edges[1]) return DIR_LEFT;
        else               return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/btn_edge_det.sv
// Rising-edge detector for one synchronised button level. clr_i suppresses the
// pulse while the history still tracks the live level, so a held button never re-fires.
module btn_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic level_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_i;
        end
    end

    assign rise_o = level_i & ~prev_q & ~clr_i;

endmodule

// File: rtl/maze_nav_ctrl.sv
// Maze navigation controller: turns button edges into single-cell moves,
// checking the addressed wall-map word and the grid bounds before moving.
module maze_nav_ctrl
    import maze_pkg::*;
#(
    parameter logic [2:0] GOAL_ROW = 3'd4,
    parameter logic [2:0] GOAL_COL = 3'd4,
    parameter int         CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic [3:0]       walls,
    input  logic [2:0]       num_rows,
    input  logic [2:0]       num_cols,
    output logic [2:0]       q_row,
    output logic [2:0]       q_col,
    output logic [2:0]       player_row,
    output logic [2:0]       player_col,
    output logic             move_ok,
    output logic             move_blocked,
    output logic             goal_reached,
    output logic [CNT_W-1:0] move_count,
    output logic             busy
);

    logic [3:0]       btn_lvl;
    logic [3:0]       rise;
    state_e           state_q;
    dir_e             dir_q;
    logic [2:0]       player_row_q;
    logic [2:0]       player_col_q;
    logic [CNT_W-1:0] move_count_q;
    logic             move_ok_q;
    logic             move_blocked_q;
    logic             goal_q;
    logic             busy_q;

    logic [2:0]       next_row_d;
    logic [2:0]       next_col_d;
    logic             blocked_d;
    logic [2:0]       row_last;
    logic [2:0]       col_last;

    assign btn_lvl = {btn_up, btn_down, btn_left, btn_right};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_edge
            btn_edge_det u_edge (
                .clk     (clk),
                .rst     (rst),
                .clr_i   (restart),
                .level_i (btn_lvl[gi]),
                .rise_o  (rise[gi])
            );
        end
    endgenerate

    assign row_last = num_rows - 3'd1;
    assign col_last = num_cols - 3'd1;

    always_comb begin
        next_row_d = player_row_q;
        next_col_d = player_col_q;
        blocked_d  = 1'b0;
        case (dir_q)
            DIR_UP: begin
                blocked_d  = walls[WALL_T] || (player_row_q == 3'd0);
                next_row_d = player_row_q - 3'd1;
            end
            DIR_DOWN: begin
                blocked_d  = walls[WALL_B] || (player_row_q >= row_last);
                next_row_d = player_row_q + 3'd1;
            end
            DIR_LEFT: begin
                blocked_d  = walls[WALL_L] || (player_col_q == 3'd0);
                next_col_d = player_col_q - 3'd1;
            end
            DIR_RIGHT: begin
                blocked_d  = walls[WALL_R] || (player_col_q >= col_last);
                next_col_d = player_col_q + 3'd1;
            end
            default: begin
                blocked_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            dir_q          <= DIR_UP;
            player_row_q   <= 3'd0;
            player_col_q   <= 3'd0;
            move_count_q   <= '0;
            move_ok_q      <= 1'b0;
            move_blocked_q <= 1'b0;
            goal_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else if (restart) begin
            state_q        <= ST_IDLE;
            dir_q          <= DIR_UP;
            player_row_q   <= 3'd0;
            player_col_q   <= 3'd0;
            move_count_q   <= '0;
            move_ok_q      <= 1'b0;
            move_blocked_q <= 1'b0;
            goal_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            move_ok_q      <= 1'b0;
            move_blocked_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if ((|rise) && !goal_q) begin
                        dir_q   <= pick_dir(rise);
                        state_q <= ST_LOOKUP;
                        busy_q  <= 1'b1;
                    end
                end
                // The wall map is addressed by the player cell; give it a cycle to settle.
                ST_LOOKUP: begin
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (blocked_d) begin
                        move_blocked_q <= 1'b1;
                    end else begin
                        move_ok_q    <= 1'b1;
                        player_row_q <= next_row_d;
                        player_col_q <= next_col_d;
                        if (move_count_q != {CNT_W{1'b1}}) begin
                            move_count_q <= move_count_q + 1'b1;
                        end
                        if ((next_row_d == GOAL_ROW) && (next_col_d == GOAL_COL)) begin
                            goal_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q_row        = player_row_q;
    assign q_col        = player_col_q;
    assign player_row   = player_row_q;
    assign player_col   = player_col_q;
    assign move_ok      = move_ok_q;
    assign move_blocked = move_blocked_q;
    assign goal_reached = goal_q;
    assign move_count   = move_count_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_maze_nav_ctrl.sv
// Bench for maze_nav_ctrl: table of single moves, hand sequences for goal,
// restart, simultaneous edges, counter saturation and mid-move reset.
module tb_maze_nav_ctrl;

    localparam logic [3:0] B_U = 4'b1000;
    localparam logic [3:0] B_D = 4'b0100;
    localparam logic [3:0] B_L = 4'b0010;
    localparam logic [3:0] B_R = 4'b0001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       restart = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [3:0] walls = 4'b0000;
    logic [2:0] num_rows = 3'd5;
    logic [2:0] num_cols = 3'd5;
    logic [2:0] q_row, q_col, player_row, player_col;
    logic       move_ok, move_blocked, goal_reached, busy;
    logic [7:0] move_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] btns;
        logic [3:0] walls;
        logic       ok;
        logic [2:0] row;
        logic [2:0] col;
        int         cnt;
        logic       goal;
    } vec_t;

    typedef struct {
        logic       ok;
        logic [2:0] row;
        logic [2:0] col;
        int         cnt;
        logic       goal;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[15];

    maze_nav_ctrl #(.GOAL_ROW(3'd4), .GOAL_COL(3'd4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .restart      (restart),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .walls        (walls),
        .num_rows     (num_rows),
        .num_cols     (num_cols),
        .q_row        (q_row),
        .q_col        (q_col),
        .player_row   (player_row),
        .player_col   (player_col),
        .move_ok      (move_ok),
        .move_blocked (move_blocked),
        .goal_reached (goal_reached),
        .move_count   (move_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_state(input string nm, input logic [2:0] r, input logic [2:0] c,
                             input int cnt, input logic g);
        chk({nm, "_row"}, 32'(player_row), 32'(r));
        chk({nm, "_col"}, 32'(player_col), 32'(c));
        chk({nm, "_qrow"}, 32'(q_row), 32'(r));
        chk({nm, "_qcol"}, 32'(q_col), 32'(c));
        chk({nm, "_cnt"}, 32'(move_count), 32'(cnt));
        chk({nm, "_goal"}, 32'(goal_reached), 32'(g));
    endtask

    // Scoreboard consumer: every result pulse must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (move_ok || move_blocked) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse actual=ok%0d/blk%0d expected=none",
                             move_ok, move_blocked);
                end else begin
                    e = sb_q.pop_front();
                    chk("move_ok", 32'(move_ok), 32'(e.ok));
                    chk("move_blocked", 32'(move_blocked), 32'(!e.ok));
                    chk_state("pulse", e.row, e.col, e.cnt, e.goal);
                end
            end
        end
    end

    task automatic press(input logic [3:0] b, input logic [3:0] w, input logic ok,
                         input logic [2:0] r, input logic [2:0] c, input int cnt,
                         input logic g);
        exp_t e;
        @(negedge clk);
        walls = w;
        e.ok = ok; e.row = r; e.col = c; e.cnt = cnt; e.goal = g;
        sb_q.push_back(e);
        {btn_up, btn_down, btn_left, btn_right} = b;
        @(posedge clk); #1;
        chk("busy_lookup", 32'(busy), 32'd1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); #2;
        chk("latency", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        @(posedge clk); #1;
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int exp_cnt;
        logic [2:0] c;

        vecs[0]  = '{B_L, 4'b1110, 1'b0, 3'd0, 3'd0, 0,  1'b0};
        vecs[1]  = '{B_R, 4'b1110, 1'b1, 3'd0, 3'd1, 1,  1'b0};
        vecs[2]  = '{B_U, 4'b0000, 1'b0, 3'd0, 3'd1, 1,  1'b0};
        vecs[3]  = '{B_L, 4'b0010, 1'b0, 3'd0, 3'd1, 1,  1'b0};
        vecs[4]  = '{B_L, 4'b0000, 1'b1, 3'd0, 3'd0, 2,  1'b0};
        vecs[5]  = '{B_D, 4'b0000, 1'b1, 3'd1, 3'd0, 3,  1'b0};
        vecs[6]  = '{B_D, 4'b0000, 1'b1, 3'd2, 3'd0, 4,  1'b0};
        vecs[7]  = '{B_D, 4'b0000, 1'b1, 3'd3, 3'd0, 5,  1'b0};
        vecs[8]  = '{B_D, 4'b0000, 1'b1, 3'd4, 3'd0, 6,  1'b0};
        vecs[9]  = '{B_D, 4'b0000, 1'b0, 3'd4, 3'd0, 6,  1'b0};
        vecs[10] = '{B_R, 4'b0001, 1'b0, 3'd4, 3'd0, 6,  1'b0};
        vecs[11] = '{B_R, 4'b0000, 1'b1, 3'd4, 3'd1, 7,  1'b0};
        vecs[12] = '{B_R, 4'b0000, 1'b1, 3'd4, 3'd2, 8,  1'b0};
        vecs[13] = '{B_R, 4'b0000, 1'b1, 3'd4, 3'd3, 9,  1'b0};
        vecs[14] = '{B_R, 4'b0100, 1'b1, 3'd4, 3'd4, 10, 1'b1};

        #1;
        chk_state("reset", 3'd0, 3'd0, 0, 1'b0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ok", 32'(move_ok), 32'd0);
        chk("reset_blk", 32'(move_blocked), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            press(vecs[i].btns, vecs[i].walls, vecs[i].ok, vecs[i].row, vecs[i].col,
                  vecs[i].cnt, vecs[i].goal);
            $display("vec %0d btns=%b walls=%b -> player=(%0d,%0d) count=%0d goal=%0d",
                     i, vecs[i].btns, vecs[i].walls, player_row, player_col,
                     move_count, goal_reached);
        end

        // Goal reached: further edges are ignored.
        @(negedge clk);
        walls = 4'b0000;
        btn_up = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("goal_ignore_busy", 32'(busy), 32'd0);
        chk_state("goal_ignore", 3'd4, 3'd4, 10, 1'b1);
        btn_up = 1'b0;

        @(negedge clk);
        restart = 1'b1;
        @(posedge clk); #1;
        chk_state("restart", 3'd0, 3'd0, 0, 1'b0);
        @(negedge clk);
        restart = 1'b0;
        $display("restart -> player=(%0d,%0d) goal=%0d", player_row, player_col, goal_reached);

        // Restart during a move cancels it; the still-held button must not re-fire.
        @(negedge clk);
        btn_right = 1'b1;
        @(posedge clk);
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk); #1;
        chk("restart_busy", 32'(busy), 32'd0);
        @(negedge clk);
        restart = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_state("restart_abort", 3'd0, 3'd0, 0, 1'b0);
        btn_right = 1'b0;
        $display("restart mid-move -> player=(%0d,%0d) busy=%0d", player_row, player_col, busy);

        press(B_D, 4'b0000, 1'b1, 3'd1, 3'd0, 1, 1'b0);
        press(B_D, 4'b0000, 1'b1, 3'd2, 3'd0, 2, 1'b0);
        press(B_R, 4'b0000, 1'b1, 3'd2, 3'd1, 3, 1'b0);
        press(B_R, 4'b0000, 1'b1, 3'd2, 3'd2, 4, 1'b0);
        press(B_U | B_R, 4'b0000, 1'b1, 3'd1, 3'd2, 5, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk_state("simul", 3'd1, 3'd2, 5, 1'b0);
        $display("up+right -> player=(%0d,%0d)", player_row, player_col);

        // Bounce left/right until the counter must saturate.
        exp_cnt = 5;
        c = 3'd2;
        for (int i = 0; i < 260; i++) begin
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            c = (c == 3'd2) ? 3'd1 : 3'd2;
            press((c == 3'd1) ? B_L : B_R, 4'b0000, 1'b1, 3'd1, c, exp_cnt, 1'b0);
        end
        $display("saturation -> count=%0d", move_count);
        chk("sat_count", 32'(move_count), 32'd255);

        // Reset while in LOOKUP: outputs clear at once and no pulse follows.
        @(negedge clk);
        btn_down = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk_state("midrst", 3'd0, 3'd0, 0, 1'b0);
        chk("midrst_busy", 32'(busy), 32'd0);
        btn_down = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk_state("post_rst", 3'd0, 3'd0, 0, 1'b0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        $display("reset in LOOKUP -> player=(%0d,%0d) busy=%0d", player_row, player_col, busy);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
